host_bus_arbiter: RTL and testbench

- Shares one single-beat AXI host-bus master among N_REQ requesters (CPU port, DMA, debug).
- Arbitrates and latches the winner's command, then drives the master's host bus.
- Waits for completion, issues the master clear, and returns read data and status to the winning requester.
- Sits between the requesters and the master; the requesters never see the master directly.

---
 rtl/host_bus_pkg.sv | 30 +++
 rtl/host_bus_arbiter_if.sv | 26 ++
 rtl/host_arb_picker.sv | 48 ++++
 rtl/host_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_host_bus_arbiter.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/host_bus_pkg.sv
// Shared encodings for the host-bus arbiter: rw codes, size codes and arbiter states.
`timescale 1ns/1ps
package host_bus_pkg;

    typedef enum logic [1:0] {
        RW_NOP   = 2'b00,
        RW_WRITE = 2'b01,
        RW_READ  = 2'b10
    } rw_e;

    typedef enum logic [2:0] {
        SIZE_BYTE  = 3'd0,
        SIZE_HALF  = 3'd1,
        SIZE_WORD  = 3'd2,
        SIZE_DWORD = 3'd3
    } size_e;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    // Only 01 and 10 are real commands; 00 and 11 are both ignored.
    function automatic logic rw_valid(input logic [1:0] rw);
        return rw[1] ^ rw[0];
    endfunction

endpackage

// File: rtl/host_bus_arbiter_if.sv
// Command/response bus between the arbiter (master modport) and the shared host-bus master (slave modport).
`timescale 1ns/1ps
interface host_bus_arbiter_if;
    logic [2:0]  m_size;
    logic [31:0] m_addr;
    logic [63:0] m_wdata;
    logic [1:0]  m_rw;
    logic        m_clear;
    logic [63:0] m_rdata;
    logic        m_wait;
    logic        m_done;
    logic        m_error;
    logic        m_invalid;

    // Handshake: m_rw is a one-cycle command; the master answers with m_wait while busy,
    // then m_done (with m_wait low) holding status/rdata until it sees m_clear.
    modport master (
        output m_size, m_addr, m_wdata, m_rw, m_clear,
        input  m_rdata, m_wait, m_done, m_error, m_invalid
    );

    modport slave (
        input  m_size, m_addr, m_wdata, m_rw, m_clear,
        output m_rdata, m_wait, m_done, m_error, m_invalid
    );
endinterface

// File: rtl/host_arb_picker.sv
// Combinational one-hot winner select. HOST_ARB_RR_EN selects round-robin from ptr+1; otherwise lowest index wins.
`timescale 1ns/1ps
module host_arb_picker #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
`ifdef HOST_ARB_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic             any,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);

`ifdef HOST_ARB_RR_EN
    always_comb begin
        int j;
        any = 1'b0;
        gnt = '0;
        idx = '0;
        j   = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end
`else
    always_comb begin
        any = 1'b0;
        gnt = '0;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any && req[i]) begin
                any    = 1'b1;
                gnt[i] = 1'b1;
                idx    = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/host_bus_arbiter.sv
// Shares one single-beat host-bus master among N_REQ requesters.
// Optional macro HOST_ARB_RR_EN: round-robin arbitration instead of fixed priority.
`timescale 1ns/1ps
module host_bus_arbiter
    import host_bus_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2*N_REQ-1:0]  i_req_rw,
    input  logic [3*N_REQ-1:0]  i_req_size,
    input  logic [32*N_REQ-1:0] i_req_addr,
    input  logic [64*N_REQ-1:0] i_req_wdata,
    output logic [N_REQ-1:0]    o_req_gnt,
    output logic [N_REQ-1:0]    o_req_done,
    output logic [63:0]         o_rdata,
    output logic                o_error,
    output logic                o_invalid,
    output logic                o_busy,
    output arb_state_e          o_state,
    host_bus_arbiter_if.master  bus
);

    arb_state_e         state;
    logic [IDX_W-1:0]   owner;
    logic [1:0]         lat_rw;
    logic [2:0]         lat_size;
    logic [31:0]        lat_addr;
    logic [63:0]        lat_wdata;
    logic [1:0]         m_rw_q;
    logic               clear_q;
    logic               st_err;
    logic               st_inv;
    logic [N_REQ-1:0]   done_q;

    logic [N_REQ-1:0]   req_vec;
    logic               pick_any;
    logic [N_REQ-1:0]   pick_gnt;
    logic [IDX_W-1:0]   pick_idx;

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < N_REQ; i++) req_vec[i] = rw_valid(i_req_rw[2*i +: 2]);
    end

`ifdef HOST_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;
`endif

    host_arb_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
        .req (req_vec),
`ifdef HOST_ARB_RR_EN
        .ptr (rr_ptr),
`endif
        .any (pick_any),
        .gnt (pick_gnt),
        .idx (pick_idx)
    );

    assign o_req_gnt   = (state == ARB_IDLE && !i_rst) ? pick_gnt : '0;
    assign o_req_done  = done_q;
    assign o_busy      = (state != ARB_IDLE);
    assign o_state     = state;
    assign bus.m_size  = lat_size;
    assign bus.m_addr  = lat_addr;
    assign bus.m_wdata = lat_wdata;
    assign bus.m_rw    = m_rw_q;
    assign bus.m_clear = clear_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ARB_IDLE;
            owner     <= '0;
            lat_rw    <= RW_NOP;
            lat_size  <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            m_rw_q    <= RW_NOP;
            clear_q   <= 1'b0;
            st_err    <= 1'b0;
            st_inv    <= 1'b0;
            done_q    <= '0;
            o_rdata   <= '0;
            o_error   <= 1'b0;
            o_invalid <= 1'b0;
`ifdef HOST_ARB_RR_EN
            rr_ptr    <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            done_q <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        lat_rw    <= i_req_rw[2*pick_idx +: 2];
                        lat_size  <= i_req_size[3*pick_idx +: 3];
                        lat_addr  <= i_req_addr[32*pick_idx +: 32];
                        lat_wdata <= i_req_wdata[64*pick_idx +: 64];
                        m_rw_q    <= i_req_rw[2*pick_idx +: 2];
                        state     <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    // Misaligned commands complete in the issue cycle without ever raising m_wait.
                    if (bus.m_wait) begin
                        m_rw_q <= RW_NOP;
                        state  <= ARB_WAIT;
                    end else if (bus.m_done) begin
                        st_err  <= bus.m_error;
                        st_inv  <= bus.m_invalid;
                        m_rw_q  <= RW_NOP;
                        clear_q <= 1'b1;
                        state   <= ARB_RESP;
                    end
                end
                ARB_WAIT: begin
                    if (bus.m_done && !bus.m_wait) begin
                        st_err  <= bus.m_error;
                        st_inv  <= bus.m_invalid;
                        clear_q <= 1'b1;
                        state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    clear_q   <= 1'b0;
                    o_rdata   <= (lat_rw == RW_READ && !st_inv) ? bus.m_rdata : 64'd0;
                    o_error   <= st_err;
                    o_invalid <= st_inv;
                    done_q    <= N_REQ'(1) << owner;
`ifdef HOST_ARB_RR_EN
                    rr_ptr    <= owner;
`endif
                    state     <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_host_bus_arbiter.sv
// Directed bench for host_bus_arbiter; the shared master is played inline by the stimulus sequence.
`timescale 1ns/1ps
module tb_host_bus_arbiter;
    import host_bus_pkg::*;

    localparam int N     = 4;
    localparam int EXP_W = N + 66;

    // clock / reset
    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    always #5 i_clk = ~i_clk;

    logic [1:0]  rw [N];
    logic [2:0]  sz [N];
    logic [31:0] ad [N];
    logic [63:0] wd [N];

    logic [2*N-1:0]  req_rw_v;
    logic [3*N-1:0]  req_size_v;
    logic [32*N-1:0] req_addr_v;
    logic [64*N-1:0] req_wdata_v;

    always_comb begin
        req_rw_v    = '0;
        req_size_v  = '0;
        req_addr_v  = '0;
        req_wdata_v = '0;
        for (int i = 0; i < N; i++) begin
            req_rw_v[2*i +: 2]     = rw[i];
            req_size_v[3*i +: 3]   = sz[i];
            req_addr_v[32*i +: 32] = ad[i];
            req_wdata_v[64*i +: 64] = wd[i];
        end
    end

    logic [N-1:0] o_req_gnt, o_req_done;
    logic [63:0]  o_rdata;
    logic         o_error, o_invalid, o_busy;
    arb_state_e   o_state;

    host_bus_arbiter_if bus_if ();

    host_bus_arbiter #(.N_REQ(N)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_rw    (req_rw_v),
        .i_req_size  (req_size_v),
        .i_req_addr  (req_addr_v),
        .i_req_wdata (req_wdata_v),
        .o_req_gnt   (o_req_gnt),
        .o_req_done  (o_req_done),
        .o_rdata     (o_rdata),
        .o_error     (o_error),
        .o_invalid   (o_invalid),
        .o_busy      (o_busy),
        .o_state     (o_state),
        .bus         (bus_if)
    );

    // scoreboard: {done one-hot, rdata, error, invalid}
    logic [EXP_W-1:0] exp_q[$];
    int vectors    = 0;
    int miscompares = 0;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int owner, input logic [63:0] rd, input logic er, input logic iv);
        logic [N-1:0] oh;
        oh = '0;
        oh[owner] = 1'b1;
        exp_q.push_back({oh, rd, er, iv});
    endtask

    task automatic check_done();
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL sb_empty: observed done=%b expected a queued result", o_req_done);
        end else begin
            e = exp_q.pop_front();
            chk("done",    64'(o_req_done), 64'(e[EXP_W-1 -: N]));
            chk("rdata",   o_rdata,         e[65:2]);
            chk("error",   64'(o_error),    64'(e[1]));
            chk("invalid", 64'(o_invalid),  64'(e[0]));
        end
    endtask

    // Called in the ARB_ISSUE cycle; returns in the cycle where o_req_done should be high.
    task automatic serve(input int n_wait, input logic [63:0] rd, input logic er, input logic iv);
        if (n_wait < 0) begin
            bus_if.m_done = 1'b1; bus_if.m_rdata = rd;
            bus_if.m_error = er;  bus_if.m_invalid = iv;
            step();
        end else begin
            bus_if.m_wait = 1'b1;
            step();
            chk("wait_rw", 64'(bus_if.m_rw), 64'(RW_NOP));
            repeat (n_wait) step();
            bus_if.m_wait = 1'b0; bus_if.m_done = 1'b1; bus_if.m_rdata = rd;
            bus_if.m_error = er;  bus_if.m_invalid = iv;
            step();
        end
        chk("resp_clear", 64'(bus_if.m_clear), 64'd1);
        chk("resp_rw",    64'(bus_if.m_rw),    64'(RW_NOP));
        step();
        bus_if.m_done = 1'b0; bus_if.m_error = 1'b0; bus_if.m_invalid = 1'b0; bus_if.m_rdata = '0;
        chk("clear_low",  64'(bus_if.m_clear), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_w;
        for (int i = 0; i < N; i++) begin
            rw[i] = RW_NOP; sz[i] = '0; ad[i] = '0; wd[i] = '0;
        end
        bus_if.m_rdata = '0; bus_if.m_wait = 1'b0; bus_if.m_done = 1'b0;
        bus_if.m_error = 1'b0; bus_if.m_invalid = 1'b0;

        // reset values
        repeat (3) step();
        chk("rst_busy",  64'(o_busy),        64'd0);
        chk("rst_done",  64'(o_req_done),    64'd0);
        chk("rst_rdata", o_rdata,            64'd0);
        chk("rst_m_rw",  64'(bus_if.m_rw),   64'd0);
        chk("rst_clear", 64'(bus_if.m_clear), 64'd0);
        chk("rst_addr",  64'(bus_if.m_addr), 64'd0);
        chk("rst_state", 64'(o_state),       64'(ARB_IDLE));
        i_rst = 1'b0;
        step();

        // req1 read, normal completion after wait
        rw[1] = RW_READ; ad[1] = 32'h1000; sz[1] = SIZE_DWORD;
        #1;
        chk("t1_gnt", 64'(o_req_gnt), 64'b0010);
        push_exp(1, 64'h1122334455667788, 1'b0, 1'b0);
        step();
        rw[1] = RW_NOP;
        chk("t1_m_rw",   64'(bus_if.m_rw),   64'(RW_READ));
        chk("t1_m_addr", 64'(bus_if.m_addr), 64'h1000);
        chk("t1_m_size", 64'(bus_if.m_size), 64'd3);
        chk("t1_busy",   64'(o_busy),        64'd1);
        serve(2, 64'h1122334455667788, 1'b0, 1'b0);
        check_done();

        // req0 misaligned write, reported in the issue cycle: done 3 cycles after grant
        rw[0] = RW_WRITE; ad[0] = 32'h2002; sz[0] = SIZE_WORD; wd[0] = 64'h0badc0de12345678;
        #1;
        chk("t2_gnt", 64'(o_req_gnt), 64'b0001);
        push_exp(0, 64'd0, 1'b1, 1'b1);
        step();
        rw[0] = RW_NOP;
        chk("t2_m_rw",    64'(bus_if.m_rw), 64'(RW_WRITE));
        chk("t2_m_wdata", bus_if.m_wdata,   64'h0badc0de12345678);
        serve(-1, 64'hffffffffffffffff, 1'b1, 1'b1);
        check_done();

        // req2 write SLVERR while req3 also waits; req3 granted in the done cycle
        rw[2] = RW_WRITE; ad[2] = 32'h3000; sz[2] = SIZE_DWORD; wd[2] = 64'h5555aaaa5555aaaa;
        rw[3] = RW_READ;  ad[3] = 32'h4000; sz[3] = SIZE_DWORD;
        #1;
        chk("t3_gnt", 64'(o_req_gnt), 64'b0100);
        push_exp(2, 64'd0, 1'b1, 1'b0);
        step();
        rw[2] = RW_NOP;
        chk("t3_m_addr", 64'(bus_if.m_addr), 64'h3000);
        serve(0, 64'hdeadbeefdeadbeef, 1'b1, 1'b0);
        check_done();
        chk("t3_next_gnt", 64'(o_req_gnt), 64'b1000);
        push_exp(3, 64'hcafef00dcafef00d, 1'b0, 1'b0);
        step();
        rw[3] = RW_NOP;
        chk("t3b_m_addr", 64'(bus_if.m_addr), 64'h4000);
        serve(1, 64'hcafef00dcafef00d, 1'b0, 1'b0);
        check_done();

        // all four requesting continuously
        for (int i = 0; i < N; i++) begin
            rw[i] = RW_READ; ad[i] = 32'h100 * (i + 1); sz[i] = SIZE_DWORD;
        end
        #1;
        for (int k = 0; k < 5; k++) begin
`ifdef HOST_ARB_RR_EN
            exp_w = k % N;
`else
            exp_w = 0;
`endif
            chk("t4_gnt", 64'(o_req_gnt), 64'(1) << exp_w);
            push_exp(exp_w, 64'ha000 + 64'(k), 1'b0, 1'b0);
            step();
            chk("t4_m_addr", 64'(bus_if.m_addr), 64'(32'h100 * (exp_w + 1)));
            serve(0, 64'ha000 + 64'(k), 1'b0, 1'b0);
            if (k == 4) for (int i = 0; i < N; i++) rw[i] = RW_NOP;
            check_done();
        end
        step();
        chk("t4_idle", 64'(o_busy), 64'd0);

        // reset during ARB_WAIT aborts without a result
        rw[1] = RW_WRITE; ad[1] = 32'h5000; sz[1] = SIZE_DWORD; wd[1] = 64'h77;
        #1;
        chk("t5_gnt", 64'(o_req_gnt), 64'b0010);
        step();
        rw[1] = RW_NOP;
        bus_if.m_wait = 1'b1;
        step();
        chk("t5_state_wait", 64'(o_state), 64'(ARB_WAIT));
        i_rst = 1'b1;
        #1;
        chk("t5_rst_busy",  64'(o_busy),          64'd0);
        chk("t5_rst_m_rw",  64'(bus_if.m_rw),     64'd0);
        chk("t5_rst_clear", 64'(bus_if.m_clear),  64'd0);
        chk("t5_rst_addr",  64'(bus_if.m_addr),   64'd0);
        chk("t5_rst_wdata", bus_if.m_wdata,       64'd0);
        chk("t5_rst_state", 64'(o_state),         64'(ARB_IDLE));
        bus_if.m_wait = 1'b0;
        step();
        chk("t5_no_done_a", 64'(o_req_done), 64'd0);
        i_rst = 1'b0;
        step();
        chk("t5_no_done_b", 64'(o_req_done), 64'd0);
        rw[1] = RW_WRITE;
        #1;
        chk("t5_regnt", 64'(o_req_gnt), 64'b0010);
        push_exp(1, 64'd0, 1'b0, 1'b0);
        step();
        rw[1] = RW_NOP;
        chk("t5_m_addr", 64'(bus_if.m_addr), 64'h5000);
        serve(0, 64'h1234, 1'b0, 1'b0);
        check_done();

        // rw=11 is not a request
        rw[3] = 2'b11;
        #1;
        chk("t6_gnt", 64'(o_req_gnt), 64'd0);
        step();
        chk("t6_busy",  64'(o_busy),  64'd0);
        chk("t6_state", 64'(o_state), 64'(ARB_IDLE));
        rw[3] = RW_NOP;
        step();
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
